json_tokenizer: RTL

- Streaming JSON lexer: one byte per cycle in, one classified byte per cycle out.
- Sits between the byte source and the JSON parser.
- Drops whitespace outside strings and tags every other byte with token kind, first/last markers and nesting depth.
- Detects lexical and nesting errors; the error flag is sticky.
- Grammar ordering (comma/colon placement) is not checked here.

---
 rtl/json_pkg.sv | 88 ++++++++
 rtl/json_depth_stack.sv | 43 ++++
 rtl/json_tokenizer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/json_pkg.sv
// Shared types, literal ROM and character-class helpers for the streaming JSON lexer.
package json_pkg;

    typedef enum logic [3:0] {
        OBJ_OPEN,
        OBJ_CLOSE,
        ARR_OPEN,
        ARR_CLOSE,
        COLON,
        COMMA,
        STR,
        NUM,
        LIT
    } tok_kind_e;

    typedef enum logic [2:0] {
        NONE          = 3'd0,
        UNEXPECTED    = 3'd1,
        BAD_LITERAL   = 3'd2,
        DEPTH_OVF     = 3'd3,
        NEST_MISMATCH = 3'd4,
        UNBALANCED    = 3'd5,
        CTRL_IN_STR   = 3'd6
    } err_e;

    typedef enum logic [2:0] {
        S_VALUE,
        S_STR,
        S_STR_ESC,
        S_NUM,
        S_LIT,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        LIT_SEL_TRUE,
        LIT_SEL_FALSE,
        LIT_SEL_NULL
    } lit_sel_e;

    // Literal spellings packed with character 0 in the least significant byte.
    localparam logic [39:0] LIT_TRUE_ROM  = 40'h00_65_75_72_74;
    localparam logic [39:0] LIT_FALSE_ROM = 40'h65_73_6C_61_66;
    localparam logic [39:0] LIT_NULL_ROM  = 40'h00_6C_6C_75_6E;
    localparam logic [2:0]  LIT_TRUE_LEN  = 3'd4;
    localparam logic [2:0]  LIT_FALSE_LEN = 3'd5;
    localparam logic [2:0]  LIT_NULL_LEN  = 3'd4;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_num_char(input logic [7:0] c);
        return is_digit(c) || (c == 8'h2D) || (c == 8'h2B) || (c == 8'h2E) ||
               (c == 8'h65) || (c == 8'h45);
    endfunction

    function automatic logic [7:0] lit_char(input lit_sel_e sel, input logic [2:0] idx);
        logic [39:0] rom;
        logic [7:0]  c;
        case (sel)
            LIT_SEL_TRUE:  rom = LIT_TRUE_ROM;
            LIT_SEL_FALSE: rom = LIT_FALSE_ROM;
            default:       rom = LIT_NULL_ROM;
        endcase
        case (idx)
            3'd0:    c = rom[7:0];
            3'd1:    c = rom[15:8];
            3'd2:    c = rom[23:16];
            3'd3:    c = rom[31:24];
            default: c = rom[39:32];
        endcase
        return c;
    endfunction

    function automatic logic [2:0] lit_len(input lit_sel_e sel);
        case (sel)
            LIT_SEL_TRUE:  return LIT_TRUE_LEN;
            LIT_SEL_FALSE: return LIT_FALSE_LEN;
            default:       return LIT_NULL_LEN;
        endcase
    endfunction

endpackage

// File: rtl/json_depth_stack.sv
// Bracket-type stack: one bit per nesting level (1 = object), with an occupancy counter.
module json_depth_stack #(
    parameter int MAX_DEPTH = 16,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic               push_is_obj,
    output logic [DEPTH_W-1:0] depth,
    output logic               top_is_obj,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic [MAX_DEPTH-1:0] types;
    logic [DEPTH_W-1:0]   top_pos;

    assign top_pos    = depth - 1'b1;
    assign full       = (depth == DEPTH_W'(MAX_DEPTH));
    assign empty      = (depth == '0);
    assign top_is_obj = !empty && types[top_pos[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            types <= '0;
        end else if (clear) begin
            depth <= '0;
            types <= '0;
        end else if (push && !full) begin
            types[depth[IDX_W-1:0]] <= push_is_obj;
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/json_tokenizer.sv
// Streaming JSON lexer: classifies one byte per cycle, drops insignificant whitespace,
// tracks nesting depth and latches the first lexical or nesting error.
module json_tokenizer
    import json_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               tok_valid,
    input  logic               tok_ready,
    output tok_kind_e          tok_kind,
    output logic [7:0]         tok_char,
    output logic               tok_first,
    output logic               tok_last,
    output logic [DEPTH_W-1:0] tok_depth,
    output logic               tok_eod,
    output logic               err,
    output err_e               err_code
);

    state_e             state_q, state_d;
    logic [7:0]         pend_char_q, pend_char_d;
    logic               pend_first_q, pend_first_d;
    logic               pend_final_q, pend_final_d;
    lit_sel_e           lit_sel_q, lit_sel_d;
    logic [2:0]         lit_idx_q, lit_idx_d;

    logic               emit;
    tok_kind_e          e_kind;
    logic [7:0]         e_char;
    logic               e_first, e_last, e_eod;
    logic [DEPTH_W-1:0] e_depth;
    logic [DEPTH_W-1:0] depth_after;
    logic               err_set, byte_err;
    err_e               err_val;

    logic               push, pop, push_is_obj;
    logic [DEPTH_W-1:0] depth;
    logic               top_is_obj, full, empty;

    logic               out_free, flush, drain, accept;

    json_depth_stack #(.MAX_DEPTH(MAX_DEPTH)) u_stack (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .push_is_obj (push_is_obj),
        .depth       (depth),
        .top_is_obj  (top_is_obj),
        .full        (full),
        .empty       (empty)
    );

    // A held number byte is released either by a terminating byte (flush) or by in_last (drain).
    assign out_free = !tok_valid || tok_ready;
    assign drain    = (state_q == S_NUM) && pend_final_q;
    assign flush    = (state_q == S_NUM) && !pend_final_q && in_valid && !is_num_char(in_data);
    assign in_ready = !rst && (err || (out_free && !flush && !drain));
    assign accept   = in_valid && in_ready && !err;

    always_comb begin
        emit         = 1'b0;
        e_kind       = STR;
        e_char       = in_data;
        e_first      = 1'b0;
        e_last       = 1'b0;
        e_depth      = depth;
        e_eod        = 1'b0;
        state_d      = state_q;
        pend_char_d  = pend_char_q;
        pend_first_d = pend_first_q;
        pend_final_d = pend_final_q;
        lit_sel_d    = lit_sel_q;
        lit_idx_d    = lit_idx_q;
        push         = 1'b0;
        pop          = 1'b0;
        push_is_obj  = 1'b0;
        err_set      = 1'b0;
        byte_err     = 1'b0;
        err_val      = NONE;
        depth_after  = depth;

        if (out_free && (drain || flush)) begin
            emit         = 1'b1;
            e_kind       = NUM;
            e_char       = pend_char_q;
            e_first      = pend_first_q;
            e_last       = 1'b1;
            e_eod        = pend_final_q;
            pend_final_d = 1'b0;
            state_d      = S_VALUE;
            if (pend_final_q && (depth != '0)) begin
                err_set = 1'b1;
                err_val = UNBALANCED;
            end
        end else if (accept) begin
            case (state_q)
                S_VALUE: begin
                    case (in_data)
                        8'h7B, 8'h5B: begin
                            if (full) begin
                                byte_err = 1'b1;
                                err_set  = 1'b1;
                                err_val  = DEPTH_OVF;
                            end else begin
                                emit        = 1'b1;
                                e_kind      = (in_data == 8'h7B) ? OBJ_OPEN : ARR_OPEN;
                                e_first     = 1'b1;
                                e_last      = 1'b1;
                                e_depth     = depth + 1'b1;
                                push        = 1'b1;
                                push_is_obj = (in_data == 8'h7B);
                            end
                        end
                        8'h7D, 8'h5D: begin
                            if (empty || (top_is_obj != (in_data == 8'h7D))) begin
                                byte_err = 1'b1;
                                err_set  = 1'b1;
                                err_val  = NEST_MISMATCH;
                            end else begin
                                emit    = 1'b1;
                                e_kind  = (in_data == 8'h7D) ? OBJ_CLOSE : ARR_CLOSE;
                                e_first = 1'b1;
                                e_last  = 1'b1;
                                pop     = 1'b1;
                            end
                        end
                        8'h3A, 8'h2C: begin
                            emit    = 1'b1;
                            e_kind  = (in_data == 8'h3A) ? COLON : COMMA;
                            e_first = 1'b1;
                            e_last  = 1'b1;
                        end
                        8'h22: begin
                            emit    = 1'b1;
                            e_kind  = STR;
                            e_first = 1'b1;
                            state_d = S_STR;
                        end
                        8'h74, 8'h66, 8'h6E: begin
                            emit      = 1'b1;
                            e_kind    = LIT;
                            e_first   = 1'b1;
                            lit_sel_d = (in_data == 8'h74) ? LIT_SEL_TRUE :
                                        (in_data == 8'h66) ? LIT_SEL_FALSE : LIT_SEL_NULL;
                            lit_idx_d = 3'd1;
                            state_d   = S_LIT;
                        end
                        default: begin
                            if (is_ws(in_data)) begin
                            end else if ((in_data == 8'h2D) || is_digit(in_data)) begin
                                pend_char_d  = in_data;
                                pend_first_d = 1'b1;
                                pend_final_d = in_last;
                                state_d      = S_NUM;
                            end else begin
                                byte_err = 1'b1;
                                err_set  = 1'b1;
                                err_val  = UNEXPECTED;
                            end
                        end
                    endcase
                end
                S_STR: begin
                    if (in_data < 8'h20) begin
                        byte_err = 1'b1;
                        err_set  = 1'b1;
                        err_val  = CTRL_IN_STR;
                    end else begin
                        emit   = 1'b1;
                        e_kind = STR;
                        if (in_data == 8'h5C) begin
                            state_d = S_STR_ESC;
                        end else if (in_data == 8'h22) begin
                            e_last  = 1'b1;
                            state_d = S_VALUE;
                        end
                    end
                end
                S_STR_ESC: begin
                    emit    = 1'b1;
                    e_kind  = STR;
                    state_d = S_STR;
                end
                S_NUM: begin
                    // Only number bytes are accepted here; the previous one is now known not to be last.
                    emit         = 1'b1;
                    e_kind       = NUM;
                    e_char       = pend_char_q;
                    e_first      = pend_first_q;
                    pend_char_d  = in_data;
                    pend_first_d = 1'b0;
                    pend_final_d = in_last;
                end
                S_LIT: begin
                    if (in_data != lit_char(lit_sel_q, lit_idx_q)) begin
                        byte_err = 1'b1;
                        err_set  = 1'b1;
                        err_val  = BAD_LITERAL;
                    end else begin
                        emit   = 1'b1;
                        e_kind = LIT;
                        if (lit_idx_q == (lit_len(lit_sel_q) - 3'd1)) begin
                            e_last  = 1'b1;
                            state_d = S_VALUE;
                        end else begin
                            lit_idx_d = lit_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (push) begin
                depth_after = depth + 1'b1;
            end else if (pop) begin
                depth_after = depth - 1'b1;
            end

            // A number ending the document reports eod when its held byte drains.
            if (in_last && !byte_err && (state_d != S_NUM)) begin
                e_eod = emit;
                if ((state_d != S_VALUE) || (depth_after != '0)) begin
                    err_set = 1'b1;
                    err_val = UNBALANCED;
                end
            end
        end

        if (err_set) begin
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_VALUE;
            pend_char_q  <= '0;
            pend_first_q <= 1'b0;
            pend_final_q <= 1'b0;
            lit_sel_q    <= LIT_SEL_TRUE;
            lit_idx_q    <= '0;
            tok_valid    <= 1'b0;
            tok_kind     <= OBJ_OPEN;
            tok_char     <= '0;
            tok_first    <= 1'b0;
            tok_last     <= 1'b0;
            tok_depth    <= '0;
            tok_eod      <= 1'b0;
            err          <= 1'b0;
            err_code     <= NONE;
        end else if (clear) begin
            state_q      <= S_VALUE;
            pend_char_q  <= '0;
            pend_first_q <= 1'b0;
            pend_final_q <= 1'b0;
            lit_sel_q    <= LIT_SEL_TRUE;
            lit_idx_q    <= '0;
            tok_valid    <= 1'b0;
            tok_kind     <= OBJ_OPEN;
            tok_char     <= '0;
            tok_first    <= 1'b0;
            tok_last     <= 1'b0;
            tok_depth    <= '0;
            tok_eod      <= 1'b0;
            err          <= 1'b0;
            err_code     <= NONE;
        end else begin
            state_q      <= state_d;
            pend_char_q  <= pend_char_d;
            pend_first_q <= pend_first_d;
            pend_final_q <= pend_final_d;
            lit_sel_q    <= lit_sel_d;
            lit_idx_q    <= lit_idx_d;
            if (emit) begin
                tok_valid <= 1'b1;
                tok_kind  <= e_kind;
                tok_char  <= e_char;
                tok_first <= e_first;
                tok_last  <= e_last;
                tok_depth <= e_depth;
                tok_eod   <= e_eod;
            end else if (tok_ready) begin
                tok_valid <= 1'b0;
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
        end
    end

endmodule
